datamem_lsu: RTL and testbench
==============================

// Module: datamem_lsu
// PURPOSE
//  Parametrised load/store unit between the MEM pipeline stage and a synchronous data_memory.
//  Supports DATA_WIDTH of 32 or 64 and b/h/w/(d) accesses with sign/zero extension.
//  Word-crossing misaligned accesses are handled in hardware as two memory beats.
//  A valid/ready request handshake replaces single-cycle access; the pipeline stalls while req_ready=0.
// PARAMETERS
//  DATA_WIDTH    32   memory word / register width; 32 or 64 only
//  ADDR_WIDTH    10   byte-address width; the memory holds 2**ADDR_WIDTH bytes
//  MISALIGN_EN   1    1: split misaligned accesses into beats; 0: raise resp_exception instead
// PORTS
//  clk           in   1            system clock
//  reset         in   1            synchronous, active-high reset
//  req_valid     in   1            request present
//  req_ready     out  1            1 only in IDLE; transfer occurs when valid&&ready at clk edge
//  req_write     in   1            1=store, 0=load
//  req_funct3    in   3            [1:0] size 00=b 01=h 10=w 11=d; [2]=unsigned (loads)
//  req_addr      in   ADDR_WIDTH   byte address
//  req_wdata     in   DATA_WIDTH   store data, right-aligned
//  resp_valid    out  1            one-cycle completion pulse (loads and stores)
//  resp_rdata    out  DATA_WIDTH   extended load data; 0 for stores/exceptions
//  resp_exception out 1            valid with resp_valid
//  mem_addr      out  ADDR_WIDTH-$clog2(DATA_WIDTH/8)  word address
//  mem_we, mem_re out 1            single-cycle strobes, never both high
//  mem_be        out  DATA_WIDTH/8 byte enables
//  mem_wdata     out  DATA_WIDTH   lane-rotated store data
//  mem_rdata     in   DATA_WIDTH   valid the cycle after mem_re (1-cycle latency)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, and all other outputs plus internal buffers are 0.
//  Request is captured into registers at the accept edge; inputs are ignored afterwards.
//  Let B=DATA_WIDTH/8, off=addr mod B, n=1<<size; split = (off+n > B).
//  Exceptions: size=d with DATA_WIDTH=32, or split with MISALIGN_EN=0.
//    Action: IDLE->RESP without touching memory; resp_exception=1, resp_rdata=0.
//  FSM: IDLE -> BEAT0 -> [BEAT1 if split] -> [CAPT if load] -> RESP -> IDLE.
//  BEAT0: mem_addr=addr/B; be0 = ((1<<n)-1)<<off, truncated to B bits.
//  BEAT1: mem_addr=addr/B+1, wrapping modulo memory size; be1 = ((1<<n)-1)>>(B-off).
//  Store data: wdata rotated left by 8*off; the same rotated word is used for both beats.
//  Load data: beat0 is latched in BEAT1 (or CAPT); beat1 is latched in CAPT.
//    merged = (d0 & mask(be0)) | (d1 & mask(be1)), rotated right by 8*off.
//    Result is then sign- or zero-extended per funct3.
//  Latency, accept edge T to resp_valid cycle:
//    aligned store T+2; split store T+3; aligned load T+3; split load T+4; exception T+1.
//  resp_* outputs are registered and held 0 outside RESP; the pipeline has no response backpressure.
//  req_valid is ignored whenever state!=IDLE.
//  Reset mid-operation: return to IDLE next edge with no response.
//    A beat0 store already written stays written (no rollback).
// STRUCTURE
//  Package common gains: lsu_size_t enum (B,H,W,D); lsu_state_t (IDLE,BEAT0,BEAT1,CAPT,RESP);
//    and localparam helpers BYTES_OF(width).
//  Sub-module lsu_align (combinational): byte-enable generation, data rotate, merge and
//    extension; parameterised by DATA_WIDTH. The top holds the FSM and registers only.
// TESTING
//  1 DW=32: sw 0xDEADBEEF @0x10, then lw @0x10
//    -> store resp at T+2; load resp T+3 rdata=0xDEADBEEF, mem_be=1111.
//  2 DW=32: lb @0x11 on word 0xDEADBEEF -> rdata=0xFFFFFFBE; lbu -> 0x000000BE.
//  3 DW=32: sw 0x11223344 @0x0E -> beat0 word3 be=1100; beat1 word4 be=0011.
//    Following lw @0x0E -> 0x11223344 at T+4.
//  4 DW=32, MISALIGN_EN=0: lh @0x03 -> resp_valid at T+1, exception=1.
//    mem_re/mem_we stay 0 throughout.
//  5 DW=64: sd 0x0123456789ABCDEF @0x3FC -> beat1 wraps to word 0, be=0x0F.
//    Read back gives the identical value.
//  6 Assert reset during BEAT1 of a split load -> no resp_valid, req_ready=1 next cycle.
//    A new lw completes normally.

Source files
------------

// File: rtl/datamem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package datamem_lsu_pkg;

    // Access size, encoded as funct3[1:0].
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // Bytes per memory word for a given data width.
    function automatic int BYTES_OF(input int width);
        return width / 8;
    endfunction

    // True when an access of 2**size bytes at byte offset off runs past the word end.
    function automatic logic needs_split(input int off, input int size, input int bytes);
        return (off + (1 << size)) > bytes;
    endfunction

endpackage

// File: rtl/datamem_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store rotate, load merge and extension.
// Latency: purely combinational.
// Backpressure: none; the parent FSM sequences the beats.
// Ports: off/size/is_unsigned describe the access; wdata is right-aligned store data;
//        d0/d1 are the two fetched words; be0/be1 are per-beat enables; wdata_rot is the
//        lane-rotated store word; rdata_ext is the merged, extended load result.
module lsu_align
    import datamem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
    input  lsu_size_t                       size,
    input  logic                            is_unsigned,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH-1:0]           d0,
    input  logic [DATA_WIDTH-1:0]           d1,
    output logic [DATA_WIDTH/8-1:0]         be0,
    output logic [DATA_WIDTH/8-1:0]         be1,
    output logic [DATA_WIDTH-1:0]           wdata_rot,
    output logic [DATA_WIDTH-1:0]           rdata_ext
);

    localparam int NB = BYTES_OF(DATA_WIDTH);
    localparam int W  = DATA_WIDTH;

    function automatic logic [W-1:0] lanes_to_bits(input logic [NB-1:0] lanes);
        logic [W-1:0] bits;
        bits = '0;
        for (int i = 0; i < NB; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    logic [NB-1:0]   size_lanes;
    logic [2*NB-1:0] span;
    logic [2*W-1:0]  rot_l;
    logic [2*W-1:0]  rot_r;
    logic [W-1:0]    merged;
    logic [W-1:0]    aligned;
    logic [W-1:0]    keep;
    logic            sign;

    always_comb begin
        size_lanes = '0;
        for (int i = 0; i < NB; i++) begin
            size_lanes[i] = (i < (1 << size));
        end

        // Shifting the lane mask across a double-width window yields both beats at once:
        // the low half is beat 0, whatever spills into the high half belongs to beat 1.
        span = {{NB{1'b0}}, size_lanes} << off;
        be0  = span[NB-1:0];
        be1  = span[2*NB-1:NB];

        // Rotations via a duplicated word so no bits are lost off either end.
        rot_l     = {wdata, wdata} << {off, 3'b000};
        wdata_rot = rot_l[2*W-1:W];

        merged  = (d0 & lanes_to_bits(be0)) | (d1 & lanes_to_bits(be1));
        rot_r   = {merged, merged} >> {off, 3'b000};
        aligned = rot_r[W-1:0];

        keep = lanes_to_bits(size_lanes);
        case (size)
            SZ_B:    sign = aligned[7];
            SZ_H:    sign = aligned[15];
            SZ_W:    sign = aligned[31];
            default: sign = aligned[W-1];
        endcase
        sign = sign & ~is_unsigned;

        rdata_ext = (aligned & keep) | ({W{sign}} & ~keep);
    end

endmodule

// File: rtl/datamem_lsu.sv
// Load/store unit between the MEM stage and a 1-cycle-latency synchronous data memory.
// Latency from accept: store 2 (split 3), load 3 (split 4), exception 1 cycle.
// Backpressure: req_ready is high only in IDLE; responses cannot be stalled.
// Ports: req_* is the pipeline request (valid/ready), resp_* a one-cycle registered
//        completion pulse, mem_* the word-addressed memory port with byte enables.
module datamem_lsu
    import datamem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MISALIGN_EN = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_write,
    input  logic [2:0]                                req_funct3,
    input  logic [ADDR_WIDTH-1:0]                     req_addr,
    input  logic [DATA_WIDTH-1:0]                     req_wdata,
    output logic                                      resp_valid,
    output logic [DATA_WIDTH-1:0]                     resp_rdata,
    output logic                                      resp_exception,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr,
    output logic                                      mem_we,
    output logic                                      mem_re,
    output logic [DATA_WIDTH/8-1:0]                   mem_be,
    output logic [DATA_WIDTH-1:0]                     mem_wdata,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata
);

    localparam int NB  = BYTES_OF(DATA_WIDTH);
    localparam int OW  = $clog2(NB);
    localparam int WAW = ADDR_WIDTH - OW;

    lsu_state_t state, state_nxt;

    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_split;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic [DATA_WIDTH-1:0] d0_nxt, d1_nxt;

    logic                  accept;
    logic                  req_split;
    logic                  req_exc;
    logic [WAW-1:0]        word_addr;

    logic [NB-1:0]         be0, be1;
    logic [DATA_WIDTH-1:0] wdata_rot, rdata_ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);
    assign word_addr = r_addr[ADDR_WIDTH-1:OW];

    // Classification is done on the live request so an exception can answer next cycle.
    assign req_split = needs_split(int'(req_addr[OW-1:0]), int'(req_funct3[1:0]), NB);
    assign req_exc   = ((req_funct3[1:0] == 2'b11) && (DATA_WIDTH == 32)) ||
                       (req_split && (MISALIGN_EN == 0));

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .off         (r_addr[OW-1:0]),
        .size        (lsu_size_t'(r_funct3[1:0])),
        .is_unsigned (r_funct3[2]),
        .wdata       (r_wdata),
        .d0          (d0_nxt),
        .d1          (d1_nxt),
        .be0         (be0),
        .be1         (be1),
        .wdata_rot   (wdata_rot),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_exc ? RESP : BEAT0;
            BEAT0:   state_nxt = r_split ? BEAT1 : (r_write ? RESP : CAPT);
            BEAT1:   state_nxt = r_write ? RESP : CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state)
            BEAT0: begin
                mem_addr  = word_addr;
                mem_be    = be0;
                mem_we    = r_write;
                mem_re    = ~r_write;
                mem_wdata = r_write ? wdata_rot : '0;
            end
            BEAT1: begin
                mem_addr  = word_addr + WAW'(1);    // wraps at the top of memory
                mem_be    = be1;
                mem_we    = r_write;
                mem_re    = ~r_write;
                mem_wdata = r_write ? wdata_rot : '0;
            end
            default: ;
        endcase
    end

    // Read data lands one cycle after mem_re: beat 0 shows up in BEAT1 (split) or
    // CAPT (aligned), beat 1 in CAPT. The merge sees the incoming word directly so the
    // response register can load the final value on the CAPT->RESP edge.
    always_comb begin
        d0_nxt = d0;
        d1_nxt = d1;
        if (!r_write && ((state == BEAT1) || ((state == CAPT) && !r_split))) d0_nxt = mem_rdata;
        if (!r_write && (state == CAPT) && r_split) d1_nxt = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            r_write        <= 1'b0;
            r_funct3       <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_split        <= 1'b0;
            d0             <= '0;
            d1             <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            d0    <= d0_nxt;
            d1    <= d1_nxt;
            if (accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_split  <= req_split;
            end
            resp_valid     <= (state_nxt == RESP);
            resp_exception <= accept && req_exc;
            resp_rdata     <= (state == CAPT) ? rdata_ext : '0;
        end
    end

endmodule

// File: tb/tb_datamem_lsu.sv
module tb_datamem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  vld;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [63:0] req_wdata;

    // a: DW=32 split enabled, b: DW=32 split disabled, c: DW=64
    logic a_ready, a_rvalid, a_exc, a_we, a_re;
    logic [31:0] a_rdata, a_wdata, a_mrdata;
    logic [7:0]  a_maddr;
    logic [3:0]  a_be;
    logic b_ready, b_rvalid, b_exc, b_we, b_re;
    logic [31:0] b_rdata, b_wdata, b_mrdata;
    logic [7:0]  b_maddr;
    logic [3:0]  b_be;
    logic c_ready, c_rvalid, c_exc, c_we, c_re;
    logic [63:0] c_rdata, c_wdata, c_mrdata;
    logic [6:0]  c_maddr;
    logic [7:0]  c_be;

    datamem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MISALIGN_EN(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(a_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(a_rvalid), .resp_rdata(a_rdata),
        .resp_exception(a_exc), .mem_addr(a_maddr), .mem_we(a_we), .mem_re(a_re),
        .mem_be(a_be), .mem_wdata(a_wdata), .mem_rdata(a_mrdata));

    datamem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MISALIGN_EN(0)) u_b (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(b_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(b_rvalid), .resp_rdata(b_rdata),
        .resp_exception(b_exc), .mem_addr(b_maddr), .mem_we(b_we), .mem_re(b_re),
        .mem_be(b_be), .mem_wdata(b_wdata), .mem_rdata(b_mrdata));

    datamem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .MISALIGN_EN(1)) u_c (
        .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(c_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(c_rvalid), .resp_rdata(c_rdata),
        .resp_exception(c_exc), .mem_addr(c_maddr), .mem_we(c_we), .mem_re(c_re),
        .mem_be(c_be), .mem_wdata(c_wdata), .mem_rdata(c_mrdata));

    // Synchronous memories with one cycle read latency
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [63:0] mem_c [0:127];

    always @(posedge clk) begin
        if (a_we) for (int i = 0; i < 4; i++) if (a_be[i]) mem_a[a_maddr][8*i +: 8] <= a_wdata[8*i +: 8];
        if (a_re) a_mrdata <= mem_a[a_maddr];
        if (b_we) for (int i = 0; i < 4; i++) if (b_be[i]) mem_b[b_maddr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (b_re) b_mrdata <= mem_b[b_maddr];
        if (c_we) for (int i = 0; i < 8; i++) if (c_be[i]) mem_c[c_maddr][8*i +: 8] <= c_wdata[8*i +: 8];
        if (c_re) c_mrdata <= mem_c[c_maddr];
    end

    // Observation mux for the instance currently under test
    int cur;
    logic s_ready, s_rvalid, s_exc, s_we, s_re;
    logic [63:0] s_rdata, s_wdata;
    logic [7:0]  s_maddr, s_be;

    always_comb begin
        s_ready = a_ready; s_rvalid = a_rvalid; s_exc = a_exc; s_we = a_we; s_re = a_re;
        s_rdata = {32'd0, a_rdata}; s_wdata = {32'd0, a_wdata}; s_maddr = a_maddr; s_be = {4'd0, a_be};
        if (cur == 1) begin
            s_ready = b_ready; s_rvalid = b_rvalid; s_exc = b_exc; s_we = b_we; s_re = b_re;
            s_rdata = {32'd0, b_rdata}; s_wdata = {32'd0, b_wdata}; s_maddr = b_maddr; s_be = {4'd0, b_be};
        end else if (cur == 2) begin
            s_ready = c_ready; s_rvalid = c_rvalid; s_exc = c_exc; s_we = c_we; s_re = c_re;
            s_rdata = c_rdata; s_wdata = c_wdata; s_maddr = {1'b0, c_maddr}; s_be = c_be;
        end
    end

    int checks = 0;
    int errors = 0;
    int strobe_both = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Byte-level reference memory per instance, little-endian, wrapping at 1 KiB.
    logic [7:0] refm [0:2][0:1023];

    function automatic int bytes_of_sel(input int sel);
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic bit pred_split(input int sel, input logic [2:0] f3, input logic [9:0] addr);
        int nb = bytes_of_sel(sel);
        return ((int'(addr) % nb) + (1 << f3[1:0])) > nb;
    endfunction

    function automatic bit pred_exc(input int sel, input logic [2:0] f3, input logic [9:0] addr);
        if ((1 << f3[1:0]) > bytes_of_sel(sel)) return 1'b1;
        if (sel == 1 && pred_split(sel, f3, addr)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pred_lat(input int sel, input bit wr, input logic [2:0] f3, input logic [9:0] addr);
        if (pred_exc(sel, f3, addr)) return 1;
        return 2 + (pred_split(sel, f3, addr) ? 1 : 0) + (wr ? 0 : 1);
    endfunction

    function automatic logic [63:0] model_load(input int sel, input logic [9:0] addr, input logic [2:0] f3);
        logic [63:0] v = '0;
        int n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) v[8*i +: 8] = refm[sel][(int'(addr) + i) % 1024];
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        if (sel != 2) v[63:32] = '0;
        return v;
    endfunction

    task automatic model_store(input int sel, input logic [9:0] addr, input logic [2:0] f3, input logic [63:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++) refm[sel][(int'(addr) + i) % 1024] = wd[8*i +: 8];
    endtask

    // One request on instance sel; reports latency in cycles after the accept edge,
    // response data, and up to two memory beats seen on the port.
    task automatic do_req(input int sel, input bit wr, input logic [2:0] f3, input logic [9:0] addr,
                          input logic [63:0] wd, output int lat, output logic [63:0] rd,
                          output logic ex, output int nbeats, output logic [7:0] ba0,
                          output logic [7:0] bb0, output logic [7:0] ba1, output logic [7:0] bb1);
        cur = sel;
        @(negedge clk);
        check($sformatf("ready_idle_sel%0d", sel), {63'd0, s_ready}, 64'd1);
        req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        vld = 3'b000;
        vld[sel] = 1'b1;
        @(posedge clk);
        #1;
        vld = 3'b000;
        req_wdata = '0;
        lat = -1; rd = '0; ex = 1'b0; nbeats = 0;
        ba0 = '0; bb0 = '0; ba1 = '0; bb1 = '0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            if (s_we && s_re) strobe_both++;
            if (s_we || s_re) begin
                if (nbeats == 0) begin ba0 = s_maddr; bb0 = s_be; end
                else begin ba1 = s_maddr; bb1 = s_be; end
                nbeats++;
            end
            if (s_rvalid) begin lat = k; rd = s_rdata; ex = s_exc; end
        end
    endtask

    typedef struct {
        int          sel;
        bit          wr;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        bit          exp_exc;
        int          exp_lat;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];
    int         r_nb  [NV];
    logic [7:0] r_ba0 [NV];
    logic [7:0] r_be0 [NV];
    logic [7:0] r_ba1 [NV];
    logic [7:0] r_be1 [NV];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        logic [63:0] rd;
        logic ex;
        logic [7:0] ba0, bb0, ba1, bb1;
        int seen;

        tbl[0]  = '{0, 1'b1, 3'd2, 10'h010, 64'hDEADBEEF, 64'h0, 1'b0, 2};
        tbl[1]  = '{0, 1'b0, 3'd2, 10'h010, 64'h0, 64'hDEADBEEF, 1'b0, 3};
        tbl[2]  = '{0, 1'b0, 3'd0, 10'h011, 64'h0, 64'hFFFFFFBE, 1'b0, 3};
        tbl[3]  = '{0, 1'b0, 3'd4, 10'h011, 64'h0, 64'h000000BE, 1'b0, 3};
        tbl[4]  = '{0, 1'b0, 3'd1, 10'h012, 64'h0, 64'hFFFFDEAD, 1'b0, 3};
        tbl[5]  = '{0, 1'b0, 3'd5, 10'h012, 64'h0, 64'h0000DEAD, 1'b0, 3};
        tbl[6]  = '{0, 1'b1, 3'd2, 10'h00E, 64'h11223344, 64'h0, 1'b0, 3};
        tbl[7]  = '{0, 1'b0, 3'd2, 10'h00E, 64'h0, 64'h11223344, 1'b0, 4};
        tbl[8]  = '{0, 1'b0, 3'd2, 10'h010, 64'h0, 64'hDEAD1122, 1'b0, 3};
        tbl[9]  = '{0, 1'b0, 3'd1, 10'h00F, 64'h0, 64'h00002233, 1'b0, 4};
        tbl[10] = '{0, 1'b0, 3'd3, 10'h010, 64'h0, 64'h0, 1'b1, 1};
        tbl[11] = '{1, 1'b0, 3'd1, 10'h003, 64'h0, 64'h0, 1'b1, 1};
        tbl[12] = '{1, 1'b1, 3'd2, 10'h004, 64'hCAFEF00D, 64'h0, 1'b0, 2};
        tbl[13] = '{1, 1'b0, 3'd2, 10'h004, 64'h0, 64'hCAFEF00D, 1'b0, 3};
        tbl[14] = '{1, 1'b1, 3'd2, 10'h006, 64'h55, 64'h0, 1'b1, 1};
        tbl[15] = '{1, 1'b0, 3'd2, 10'h004, 64'h0, 64'hCAFEF00D, 1'b0, 3};
        tbl[16] = '{2, 1'b1, 3'd3, 10'h3FC, 64'h0123456789ABCDEF, 64'h0, 1'b0, 3};
        tbl[17] = '{2, 1'b0, 3'd3, 10'h3FC, 64'h0, 64'h0123456789ABCDEF, 1'b0, 4};
        tbl[18] = '{2, 1'b0, 3'd2, 10'h3FC, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 3};
        tbl[19] = '{2, 1'b0, 3'd6, 10'h3FC, 64'h0, 64'h0000000089ABCDEF, 1'b0, 3};
        tbl[20] = '{2, 1'b0, 3'd3, 10'h000, 64'h0, 64'h0000000001234567, 1'b0, 3};
        tbl[21] = '{0, 1'b1, 3'd2, 10'h3FE, 64'hA1B2C3D4, 64'h0, 1'b0, 3};
        tbl[22] = '{0, 1'b0, 3'd2, 10'h3FE, 64'h0, 64'hA1B2C3D4, 1'b0, 4};
        tbl[23] = '{0, 1'b0, 3'd0, 10'h000, 64'h0, 64'hFFFFFFB2, 1'b0, 3};

        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        for (int i = 0; i < 128; i++) mem_c[i] = '0;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 1024; i++) refm[s][i] = 8'h00;

        cur = 0; vld = 3'b000; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {63'd0, s_ready}, 64'd1);
        check("reset_resp_valid", {63'd0, s_rvalid}, 64'd0);
        check("reset_resp_rdata", s_rdata, 64'd0);
        check("reset_resp_exc", {63'd0, s_exc}, 64'd0);
        check("reset_mem_strobes", {62'd0, s_we, s_re}, 64'd0);
        check("reset_mem_be", {56'd0, s_be}, 64'd0);
        check("reset_mem_addr", {56'd0, s_maddr}, 64'd0);
        check("reset_mem_wdata", s_wdata, 64'd0);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            do_req(tbl[i].sel, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, lat, rd, ex, nb, ba0, bb0, ba1, bb1);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_exc", i), {63'd0, ex}, {63'd0, tbl[i].exp_exc});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            r_nb[i] = nb; r_ba0[i] = ba0; r_be0[i] = bb0; r_ba1[i] = ba1; r_be1[i] = bb1;
            if (tbl[i].wr && !tbl[i].exp_exc) model_store(tbl[i].sel, tbl[i].addr, tbl[i].f3, tbl[i].wd);
        end

        // Beat-level expectations for the interesting vectors
        check("lw_aligned_beats", 64'(r_nb[1]), 64'd1);
        check("lw_aligned_be", {56'd0, r_be0[1]}, 64'h0F);
        check("sw_split_beats", 64'(r_nb[6]), 64'd2);
        check("sw_split_addr0", {56'd0, r_ba0[6]}, 64'd3);
        check("sw_split_be0", {56'd0, r_be0[6]}, 64'h0C);
        check("sw_split_addr1", {56'd0, r_ba1[6]}, 64'd4);
        check("sw_split_be1", {56'd0, r_be1[6]}, 64'h03);
        check("exc_lh_no_mem", 64'(r_nb[11]), 64'd0);
        check("exc_sw_no_mem", 64'(r_nb[14]), 64'd0);
        check("exc_ld32_no_mem", 64'(r_nb[10]), 64'd0);
        check("sd_wrap_addr0", {56'd0, r_ba0[16]}, 64'd127);
        check("sd_wrap_be0", {56'd0, r_be0[16]}, 64'hF0);
        check("sd_wrap_addr1", {56'd0, r_ba1[16]}, 64'd0);
        check("sd_wrap_be1", {56'd0, r_be1[16]}, 64'h0F);
        check("sw32_wrap_addr0", {56'd0, r_ba0[21]}, 64'd255);
        check("sw32_wrap_addr1", {56'd0, r_ba1[21]}, 64'd0);

        // Randomised traffic against the byte-array model
        for (int t = 0; t < 300; t++) begin
            int sel;
            bit wr;
            logic [2:0] f3;
            logic [9:0] addr;
            logic [63:0] wd, exp_rd;
            bit exp_ex;
            int exp_lat;
            sel  = $urandom_range(0, 2);
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 3) == 0) ? 10'(1024 - $urandom_range(1, 8)) : 10'($urandom_range(0, 48));
            wd   = {$urandom, $urandom};
            exp_ex  = pred_exc(sel, f3, addr);
            exp_lat = pred_lat(sel, wr, f3, addr);
            exp_rd  = (exp_ex || wr) ? 64'd0 : model_load(sel, addr, f3);
            do_req(sel, wr, f3, addr, wd, lat, rd, ex, nb, ba0, bb0, ba1, bb1);
            check($sformatf("rand%0d_rdata sel%0d f3=%0d a=%0h", t, sel, f3, addr), rd, exp_rd);
            check($sformatf("rand%0d_exc", t), {63'd0, ex}, {63'd0, exp_ex});
            check($sformatf("rand%0d_latency", t), 64'(lat), 64'(exp_lat));
            if (wr && !exp_ex) model_store(sel, addr, f3, wd);
        end

        // Reset in the middle of a split load's second beat
        cur = 0;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'd2; req_addr = 10'h00E; req_wdata = '0;
        vld = 3'b001;
        @(posedge clk);
        #1;
        vld = 3'b000;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_beat1_re", {56'd0, s_re, s_maddr[6:0]}, {56'd0, 1'b1, 7'd4});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready", {63'd0, s_ready}, 64'd1);
        seen = s_rvalid ? 1 : 0;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (s_rvalid) seen++;
        end
        check("midrst_no_resp", 64'(seen), 64'd0);

        do_req(0, 1'b0, 3'd2, 10'h010, 64'h0, lat, rd, ex, nb, ba0, bb0, ba1, bb1);
        check("postrst_lw_rdata", rd, model_load(0, 10'h010, 3'd2));
        check("postrst_lw_latency", 64'(lat), 64'd3);

        check("strobes_exclusive", 64'(strobe_both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
